// File: rtl/cpu_pkg.sv
// Shared CPU constants for the HI/LO multiply unit: operand width, default
// multiplier settle time, HI/LO product split and the unit's state encoding.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int MUL_LAT_DEF = 2;

    // HI holds the upper half of the 64-bit product, LO the lower half.
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    // Wide enough for MUL_LAT-1 over the legal range 1..15.
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mul_state_e;

endpackage

// File: rtl/mul_hilo_unit.sv
// Multicycle control around the external combinational signed multiplier:
// holds operands stable for MUL_LAT edges, then captures the product into HI/LO.
module mul_hilo_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      mul_start,
    input  logic signed [WIDTH-1:0]   op_a,
    input  logic signed [WIDTH-1:0]   op_b,
    output logic        [WIDTH-1:0]   mul_x,
    output logic        [WIDTH-1:0]   mul_y,
    input  logic signed [2*WIDTH-1:0] mul_z,
    input  logic                      mthi,
    input  logic                      mtlo,
    input  logic        [WIDTH-1:0]   wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      wr_err,
    output logic        [WIDTH-1:0]   hi,
    output logic        [WIDTH-1:0]   lo
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             start_acc;
    logic             capture;
    logic             any_req;

    assign any_req = mul_start | mthi | mtlo;

    // Next-state: IDLE accepts a start; WAIT counts down and captures at zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    start_acc = 1'b1;
                    cnt_d     = LAT_M1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Registered status and operand next values.
    always_comb begin
        busy_d = (state_d == WAIT);
        done_d = capture;
        err_d  = (state_q == WAIT) && any_req;
        x_d    = start_acc ? op_a : x_q;
        y_d    = start_acc ? op_b : y_q;
    end

    // HI/LO: product capture wins; moves are honoured only in IDLE, so a move
    // issued alongside mul_start lands first and is later overwritten.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (capture) begin
            hi_d = mul_z[2*WIDTH-1:WIDTH];
            lo_d = mul_z[WIDTH-1:0];
        end else if (state_q == IDLE) begin
            if (mthi) hi_d = wr_data;
            if (mtlo) lo_d = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign mul_x  = x_q;
    assign mul_y  = y_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_err = err_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the HI/LO unit.
module tb_mul_hilo_unit;
    import cpu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic            clock;
    logic            clear;
    logic            mul_start;
    logic [W-1:0]    op_a, op_b;
    logic [W-1:0]    mul_x, mul_y;
    logic [2*W-1:0]  mul_z;
    logic            mthi, mtlo;
    logic [W-1:0]    wr_data;
    logic            busy, done, wr_err;
    logic [W-1:0]    hi, lo;

    int total = 0;
    int bad   = 0;

    mul_hilo_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clock(clock), .clear(clear), .mul_start(mul_start),
        .op_a(op_a), .op_b(op_b), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
        .busy(busy), .done(done), .wr_err(wr_err), .hi(hi), .lo(lo)
    );

    // Sibling combinational signed multiplier.
    assign mul_z = {{W{mul_x[W-1]}}, mul_x} * {{W{mul_y[W-1]}}, mul_y};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mul_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0; mul_start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        op_a = 32'h1111_1111; op_b = 32'h2222_2222; wr_data = 32'hFFFF_FFFF;
        tick(); tick();
        total++; if ({busy, done, wr_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, wr_err}); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
        total++; if ({mul_x, mul_y} !== 64'd0) begin bad++; $display("FAIL reset_xy got=%h want=0", {mul_x, mul_y}); end
        idle_inputs();
        clear = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        op_a = 32'd3; op_b = 32'hFFFF_FFFE; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL basic_busy got=%b want=10", {busy, done}); end
        total++; if (mul_x !== 32'd3 || mul_y !== 32'hFFFF_FFFE) begin bad++; $display("FAIL basic_xy got=%h/%h want=3/fffffffe", mul_x, mul_y); end
        for (int i = 1; i < LAT; i++) begin
            tick();
            total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL basic_wait got=%b want=10", {busy, done}); end
        end
        tick();
        total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL basic_done got=%b want=01", {busy, done}); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL basic_hilo got=%h_%h want=ffffffff_fffffffa", hi, lo); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_extremes();
        logic [W-1:0] av [2];
        logic [W-1:0] eh [2];
        logic [W-1:0] el [2];
        av[0] = 32'h8000_0000; eh[0] = 32'h4000_0000; el[0] = 32'h0000_0000;
        av[1] = 32'h7FFF_FFFF; eh[1] = 32'h3FFF_FFFF; el[1] = 32'h0000_0001;
        for (int t = 0; t < 2; t++) begin
            op_a = av[t]; op_b = av[t]; mul_start = 1'b1;
            tick();
            mul_start = 1'b0;
            for (int i = 1; i < LAT; i++) tick();
            tick();
            total++; if (done !== 1'b1) begin bad++; $display("FAIL extreme%0d_done got=%b want=1", t, done); end
            total++; if (hi !== eh[t] || lo !== el[t]) begin bad++; $display("FAIL extreme%0d_hilo got=%h_%h want=%h_%h", t, hi, lo, eh[t], el[t]); end
        end
        tick();
    endtask

    task automatic test_mthi_mtlo();
        int seen_done = 0;
        mthi = 1'b1; wr_data = 32'h1234_5678;
        tick(); seen_done += done;
        mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h9ABC_DEF0;
        tick(); seen_done += done;
        mtlo = 1'b0;
        tick(); seen_done += done;
        total++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin bad++; $display("FAIL mt_hilo got=%h_%h want=12345678_9abcdef0", hi, lo); end
        total++; if (seen_done != 0 || busy !== 1'b0) begin bad++; $display("FAIL mt_done got=%0d/%b want=0/0", seen_done, busy); end
        // Both moves together.
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0BAD_F00D;
        tick(); idle_inputs();
        total++; if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL mt_both got=%h_%h want=0badf00d_0badf00d", hi, lo); end
        mthi = 1'b1; mtlo = 1'b0; wr_data = 32'h1234_5678;
        tick(); idle_inputs();
    endtask

    task automatic test_busy_drop();
        op_a = 32'd6; op_b = 32'd7; mul_start = 1'b1;
        tick();
        op_a = 32'd100; op_b = 32'd200; mul_start = 1'b1; mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) begin
            tick();
            total++; if (wr_err !== 1'b1) begin bad++; $display("FAIL drop_err got=%b want=1", wr_err); end
            total++; if (mul_x !== 32'd6 || mul_y !== 32'd7 || hi !== 32'h1234_5678) begin bad++; $display("FAIL drop_hold got=%h/%h/%h want=6/7/12345678", mul_x, mul_y, hi); end
        end
        tick();
        idle_inputs();
        total++; if ({done, wr_err} !== 2'b11) begin bad++; $display("FAIL drop_capture_flags got=%b want=11", {done, wr_err}); end
        total++; if (hi !== 32'd0 || lo !== 32'd42 || mul_x !== 32'd6) begin bad++; $display("FAIL drop_capture got=%h_%h x=%h want=0_2a x=6", hi, lo, mul_x); end
        tick();
        total++; if ({busy, done, wr_err} !== 3'b000) begin bad++; $display("FAIL drop_after got=%b want=000", {busy, done, wr_err}); end
    endtask

    task automatic test_back_to_back();
        int waited;
        op_a = 32'd5; op_b = 32'd7; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin tick(); waited++; end
        total++; if (waited != LAT || hi !== 32'd0 || lo !== 32'd35) begin bad++; $display("FAIL b2b_first got=%0d %h_%h want=%0d 0_23", waited, hi, lo, LAT); end
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b want=10", {busy, done}); end
        waited = 1;
        while (done !== 1'b1 && waited < 20) begin tick(); waited++; end
        total++; if (waited != LAT + 1 || hi !== 32'd0 || lo !== 32'd1) begin bad++; $display("FAIL b2b_second got=%0d %h_%h want=%0d 0_1", waited, hi, lo, LAT + 1); end
        tick();
    endtask

    task automatic test_reset_midop();
        int seen_done = 0;
        op_a = 32'd9; op_b = 32'd9; mul_start = 1'b1;
        tick();
        mul_start = 1'b0; clear = 1'b0;
        tick();
        clear = 1'b1;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mul_x !== 32'd0) begin bad++; $display("FAIL midop_reset got=%b %h_%h x=%h want=0 0_0 x=0", busy, hi, lo, mul_x); end
        for (int i = 0; i < LAT + 2; i++) begin tick(); seen_done += done; end
        total++; if (seen_done != 0 || hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL midop_ghost got=%0d %h_%h want=0 0_0", seen_done, hi, lo); end
    endtask

    task automatic test_random();
        logic [W-1:0] m_hi, m_lo, m_x, m_y;
        logic [2*W-1:0] m_prod;
        int m_rem;
        logic m_done, m_err;
        longint sa, sb;
        int errs = 0;
        clear = 1'b0; idle_inputs(); tick(); clear = 1'b1;
        m_hi = '0; m_lo = '0; m_x = '0; m_y = '0; m_prod = '0; m_rem = 0; m_done = 0; m_err = 0;
        for (int c = 0; c < 400; c++) begin
            clear     = ($urandom_range(0, 59) != 0);
            mul_start = ($urandom_range(0, 2) == 0);
            mthi      = ($urandom_range(0, 4) == 0);
            mtlo      = ($urandom_range(0, 4) == 0);
            wr_data   = $urandom;
            op_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            op_b      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            if (!clear) begin
                m_hi = '0; m_lo = '0; m_x = '0; m_y = '0; m_rem = 0; m_done = 0; m_err = 0;
            end else if (m_rem > 0) begin
                m_err  = mul_start | mthi | mtlo;
                m_done = (m_rem == 1);
                if (m_rem == 1) begin
                    m_hi = m_prod[HI_MSB:HI_LSB];
                    m_lo = m_prod[LO_MSB:LO_LSB];
                end
                m_rem--;
            end else begin
                m_err = 0; m_done = 0;
                if (mthi) m_hi = wr_data;
                if (mtlo) m_lo = wr_data;
                if (mul_start) begin
                    m_x = op_a; m_y = op_b;
                    sa = $signed(op_a); sb = $signed(op_b);
                    m_prod = sa * sb;
                    m_rem = LAT;
                end
            end
            tick();
            total++;
            if (hi !== m_hi || lo !== m_lo || mul_x !== m_x || mul_y !== m_y ||
                busy !== (m_rem > 0) || done !== m_done || wr_err !== m_err) begin
                bad++;
                if (errs < 5) $display("FAIL rand_c%0d got=%h_%h x=%h y=%h b=%b d=%b e=%b want=%h_%h x=%h y=%h b=%b d=%b e=%b",
                    c, hi, lo, mul_x, mul_y, busy, done, wr_err, m_hi, m_lo, m_x, m_y, (m_rem > 0), m_done, m_err);
                errs++;
            end
        end
        idle_inputs(); clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; op_a = '0; op_b = '0; wr_data = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_extremes();
        test_mthi_mtlo();
        test_busy_drop();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
